// File: rtl/hd_pkg.sv
// rtl/hd_pkg.sv - shared sizes, types and FSM states for the binary-projection MAC tile
package hd_pkg;
   localparam int N_SIZE   = 16;
   localparam int M_SIZE   = 16;
   localparam int FTWIDTH  = 8;
   localparam int Div_SIZE = 512;
   localparam int BEATS    = Div_SIZE / N_SIZE;
   localparam int ACCWIDTH = FTWIDTH + $clog2(Div_SIZE) + 1;
   localparam int PSWIDTH  = FTWIDTH + $clog2(N_SIZE) + 1;
   localparam int CNTWIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef logic [FTWIDTH-1:0]         feature_t;
   typedef logic signed [ACCWIDTH-1:0] acc_t;
   typedef logic signed [PSWIDTH-1:0]  psum_t;
   typedef feature_t [N_SIZE-1:0]      feat_vec_t;
   typedef logic [M_SIZE-1:0][N_SIZE-1:0] proj_t;
   typedef acc_t [M_SIZE-1:0]          acc_vec_t;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;
endpackage

// File: rtl/hd_mac_tile_if.sv
// rtl/hd_mac_tile_if.sv - beat input and window result bundle of the MAC tile
interface hd_mac_tile_if;
   import hd_pkg::*;

   logic              in_valid;
   logic              in_clear;
   feat_vec_t         in_features;
   proj_t             in_projections;
   acc_vec_t          out_acc;
   logic [M_SIZE-1:0] out_hv;
   logic              out_valid;
   logic              out_done;
   logic              out_err;

   modport master (
      output in_valid, in_clear, in_features, in_projections,
      input  out_acc, out_hv, out_valid, out_done, out_err
   );

   modport slave (
      input  in_valid, in_clear, in_features, in_projections,
      output out_acc, out_hv, out_valid, out_done, out_err
   );
endinterface

// File: rtl/hd_dot_row.sv
// rtl/hd_dot_row.sv - one hypervector dimension: registered signed +/- sum of a beat's features
module hd_dot_row
   import hd_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  feat_vec_t         features,
   input  logic [N_SIZE-1:0] proj,
   output psum_t             psum
);
   psum_t sum;

   always_comb begin
      sum = '0;
      for (int n = 0; n < N_SIZE; n++) begin
         if (proj[n]) sum = sum + psum_t'(features[n]);
         else         sum = sum - psum_t'(features[n]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) psum <= '0;
      else     psum <= sum;
   end
endmodule

// File: rtl/hd_mac_tile.sv
// rtl/hd_mac_tile.sv - accumulates M_SIZE signed dot products over one input vector and
// publishes them with their sign-binarised hypervector slice
module hd_mac_tile
   import hd_pkg::*;
(
   input  logic        clk,
   input  logic        reset_in,
   hd_mac_tile_if.slave bus
);
   localparam logic [CNTWIDTH-1:0] LAST_BEAT = CNTWIDTH'(BEATS - 1);

   state_e              state, state_nxt;
   logic [CNTWIDTH-1:0] cnt, cnt_nxt, base_cnt;
   logic                drain_ph;
   logic                s1_valid;
   logic                beat_ok, err_set, publish, clear_now;
   psum_t               psum [M_SIZE];
   acc_t                acc  [M_SIZE];

   for (genvar m = 0; m < M_SIZE; m++) begin : g_row
      hd_dot_row u_row (
         .clk      (clk),
         .rst      (reset_in),
         .features (bus.in_features),
         .proj     (bus.in_projections[m]),
         .psum     (psum[m])
      );
   end

   // A clear is ignored during DONE so the completing window always publishes.
   assign clear_now = bus.in_clear && (state != DONE);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      base_cnt  = cnt;
      beat_ok   = 1'b0;
      err_set   = 1'b0;
      publish   = 1'b0;
      case (state)
         IDLE, ACCUM: beat_ok = bus.in_valid;
         DRAIN: begin
            err_set = bus.in_valid;
            if (drain_ph) state_nxt = DONE;
         end
         DONE: begin
            err_set   = bus.in_valid;
            publish   = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
         default: state_nxt = IDLE;
      endcase
      if (clear_now) begin
         base_cnt  = '0;
         cnt_nxt   = '0;
         state_nxt = IDLE;
         err_set   = 1'b0;
         beat_ok   = bus.in_valid;
      end
      if (beat_ok) begin
         if (base_cnt == LAST_BEAT) begin
            state_nxt = DRAIN;
            cnt_nxt   = '0;
         end else begin
            state_nxt = ACCUM;
            cnt_nxt   = base_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         state    <= IDLE;
         cnt      <= '0;
         drain_ph <= 1'b0;
         s1_valid <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         drain_ph <= (state == DRAIN) && (state_nxt == DRAIN);
         s1_valid <= beat_ok;
      end
   end

   // Accumulators restart from zero on the publishing edge so windows can run back-to-back.
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         for (int m = 0; m < M_SIZE; m++) acc[m] <= '0;
         bus.out_acc   <= '0;
         bus.out_hv    <= '0;
         bus.out_valid <= 1'b0;
         bus.out_done  <= 1'b0;
         bus.out_err   <= 1'b0;
      end else begin
         for (int m = 0; m < M_SIZE; m++) begin
            if (clear_now || publish) acc[m] <= '0;
            else if (s1_valid)        acc[m] <= acc[m] + acc_t'(psum[m]);
            if (publish) begin
               bus.out_acc[m] <= acc[m];
               bus.out_hv[m]  <= !acc[m][ACCWIDTH-1] && (acc[m] != '0);
            end
         end
         if (publish) bus.out_valid <= 1'b1;
         bus.out_done <= publish;
         if (err_set) bus.out_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_hd_mac_tile.sv
// tb/tb_hd_mac_tile.sv - scoreboard bench for hd_mac_tile with directed windows
module tb_hd_mac_tile;
   import hd_pkg::*;

   typedef struct {
      int                acc;
      logic [M_SIZE-1:0] hv;
      int                done_cyc;
      string             name;
   } exp_t;

   logic clk = 1'b0;
   logic reset_in;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t sb [$];
   exp_t mon_e;
   exp_t push_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   hd_mac_tile_if bus ();

   hd_mac_tile dut (
      .clk      (clk),
      .reset_in (reset_in),
      .bus      (bus)
   );

   task automatic check(input string nm, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (bus.out_done) begin
         if (sb.size() == 0) begin
            check("unexpected out_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            for (int m = 0; m < M_SIZE; m++)
               check($sformatf("%s acc[%0d]", mon_e.name, m), $signed(bus.out_acc[m]), mon_e.acc);
            check({mon_e.name, " hv"}, bus.out_hv, mon_e.hv);
            check({mon_e.name, " valid"}, bus.out_valid, 1);
            check({mon_e.name, " done cycle"}, cyc, mon_e.done_cyc);
         end
      end
   end

   function automatic feat_vec_t mk_feat(input int kind, input int b);
      feat_vec_t f;
      for (int n = 0; n < N_SIZE; n++) begin
         case (kind)
            0:       f[n] = feature_t'((b * N_SIZE + n) % 256);
            1:       f[n] = feature_t'(1);
            default: f[n] = feature_t'(255);
         endcase
      end
      return f;
   endfunction

   function automatic proj_t mk_proj(input int kind);
      proj_t p;
      for (int m = 0; m < M_SIZE; m++)
         for (int n = 0; n < N_SIZE; n++)
            case (kind)
               0:       p[m][n] = 1'b0;
               1:       p[m][n] = 1'b1;
               default: p[m][n] = (n % 2 == 0);
            endcase
      return p;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic beat(input feat_vec_t f, input proj_t p, input bit clr);
      bus.in_valid       = 1'b1;
      bus.in_clear       = clr;
      bus.in_features    = f;
      bus.in_projections = p;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_clear = 1'b0;
   endtask

   task automatic run_window(input string nm, input int fk, input int pk, input bit gaps,
                             input bit clr_first, input int nbeats, input bit push,
                             input int exp_acc, input logic [M_SIZE-1:0] exp_hv);
      for (int b = 0; b < nbeats; b++) begin
         beat(mk_feat(fk, b), mk_proj(pk), clr_first && (b == 0));
         if (b == nbeats - 1) begin
            if (push) begin
               push_e.acc      = exp_acc;
               push_e.hv       = exp_hv;
               push_e.done_cyc = cyc + 3;
               push_e.name     = nm;
               sb.push_back(push_e);
            end
         end else if (gaps) begin
            idle($urandom_range(0, 3));
         end
      end
   endtask

   initial begin
      reset_in           = 1'b1;
      bus.in_valid       = 1'b0;
      bus.in_clear       = 1'b0;
      bus.in_features    = '0;
      bus.in_projections = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", bus.out_valid, 0);
      check("reset out_done", bus.out_done, 0);
      check("reset out_err", bus.out_err, 0);
      check("reset out_hv", bus.out_hv, 0);
      check("reset out_acc[0]", $signed(bus.out_acc[0]), 0);
      reset_in = 1'b0;
      idle(1);

      run_window("all_plus", 0, 1, 0, 0, BEATS, 1, 65280, 16'hFFFF);
      idle(3);
      run_window("all_minus", 0, 0, 0, 0, BEATS, 1, -65280, 16'h0000);
      idle(3);
      run_window("even_odd", 0, 2, 0, 0, BEATS, 1, -256, 16'h0000);
      idle(3);
      run_window("gaps", 0, 1, 1, 0, BEATS, 1, 65280, 16'hFFFF);
      idle(3);

      run_window("pre_clear", 0, 1, 0, 0, 10, 0, 0, 16'h0000);
      run_window("clear_restart", 1, 1, 0, 1, BEATS, 1, 512, 16'hFFFF);
      idle(4);
      bus.in_clear = 1'b1;
      idle(1);
      bus.in_clear = 1'b0;
      check("clear keeps out_valid", bus.out_valid, 1);
      check("clear keeps out_acc[0]", $signed(bus.out_acc[0]), 512);

      run_window("drain_drop", 0, 1, 0, 0, BEATS, 1, 65280, 16'hFFFF);
      check("err before drain beat", bus.out_err, 0);
      beat(mk_feat(2, 0), mk_proj(1), 1'b0);
      check("err after drain beat", bus.out_err, 1);
      idle(3);

      run_window("aborted", 0, 1, 0, 0, 5, 0, 0, 16'h0000);
      check("valid before async reset", bus.out_valid, 1);
      reset_in = 1'b1;
      #1;
      check("async reset out_valid", bus.out_valid, 0);
      check("async reset out_acc[5]", $signed(bus.out_acc[5]), 0);
      check("async reset out_hv", bus.out_hv, 0);
      check("async reset out_err", bus.out_err, 0);
      @(posedge clk);
      #1;
      reset_in = 1'b0;
      idle(1);
      run_window("after_reset", 0, 1, 0, 0, BEATS, 1, 65280, 16'hFFFF);
      idle(3);

      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      check("scoreboard drained", sb.size(), 0);
      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
